// File: rtl/sdnet_to_mtpsa.sv
// sdnet_to_mtpsa: return-path adapter from the SDNet user2Switch core to the SUME AXIS fabric.
// Each SDNet output tuple (one-cycle VALID pulse) is queued in a small FIFO. The FIFO head
// becomes m_axis_tuser = {digest, tuple[47:0]} and stays constant for every beat of the packet
// it belongs to. The head is popped on the tlast handshake.
// Optional feature macro: MTPSA_DROP_FILTER_EN. When it is defined, packets whose head tuple
// has drop bit[32] set are consumed locally, and a drop_cnt output is added.
module sdnet_to_mtpsa #(
  parameter int C_AXIS_DATA_WIDTH    = 256,
  parameter int C_TUPLE_WIDTH        = 128,
  parameter int DIGEST_WIDTH         = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 304,
  parameter int TUPLE_FIFO_DEPTH     = 4
) (
  input  logic                              axis_aclk,
  input  logic                              axis_resetn,
  input  logic                              sdnet_tuple_VALID,
  input  logic [C_TUPLE_WIDTH-1:0]          sdnet_tuple_DATA,
  input  logic [DIGEST_WIDTH-1:0]           sdnet_digest_DATA,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              tuple_overflow,
  output logic [31:0]                       pkt_cnt
`ifdef MTPSA_DROP_FILTER_EN
  ,
  output logic [31:0]                       drop_cnt
`endif
);

  localparam int AW = $clog2(TUPLE_FIFO_DEPTH);

  typedef enum logic {ST_SOP, ST_PKT} state_t;

  state_t                          state_q;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] fifo_mem [TUPLE_FIFO_DEPTH];
  logic [AW-1:0]                   wr_ptr;
  logic [AW-1:0]                   rd_ptr;
  logic [AW:0]                     count;
  logic                            head_valid;
  logic                            full;
  logic                            push_ok;
  logic                            pop;
  logic                            s_hs;
  logic                            m_last_hs;
  logic                            head_drop;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] head;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] push_word;
  logic                            unused_tuple_hi;

  // Only the low 48 tuple bits (pkt_len/src/dst/drop/send_dig) travel downstream.
  assign unused_tuple_hi = ^sdnet_tuple_DATA[C_TUPLE_WIDTH-1:48];

  assign push_word  = {sdnet_digest_DATA, sdnet_tuple_DATA[47:0]};
  assign head       = fifo_mem[rd_ptr];
  assign head_valid = (count != '0);
  assign full       = (count == (AW+1)'(TUPLE_FIFO_DEPTH));

`ifdef MTPSA_DROP_FILTER_EN
  assign head_drop = head_valid & head[32];
`else
  assign head_drop = 1'b0;
`endif

  // Beats only move once their tuple is at the FIFO head. A dropped packet is sunk unconditionally.
  assign s_axis_tready = head_valid & (head_drop | m_axis_tready);
  assign m_axis_tvalid = s_axis_tvalid & head_valid & ~head_drop;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tuser  = head_valid ? head : '0;

  assign s_hs      = s_axis_tvalid & s_axis_tready;
  assign pop       = s_hs & s_axis_tlast;
  assign m_last_hs = m_axis_tvalid & m_axis_tready & s_axis_tlast;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = sdnet_tuple_VALID & (~full | pop);

  // Tuple storage. Data only, so it has no reset; occupancy is tracked by the control pointers.
  always_ff @(posedge axis_aclk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_word;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky flag: a tuple arrived while the FIFO was full and nothing was leaving.
  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn)                             tuple_overflow <= 1'b0;
    else if (sdnet_tuple_VALID & full & ~pop)     tuple_overflow <= 1'b1;
  end

  // Packet framing: SOP waits for the first beat; a single-beat packet stays in SOP.
  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      state_q <= ST_SOP;
    end else begin
      case (state_q)
        ST_SOP:  if (s_hs & ~s_axis_tlast) state_q <= ST_PKT;
        ST_PKT:  if (pop)                  state_q <= ST_SOP;
        default: state_q <= ST_SOP;
      endcase
    end
  end

  // Count forwarded packets; wraps naturally at 2^32.
  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn)   pkt_cnt <= '0;
    else if (m_last_hs) pkt_cnt <= pkt_cnt + 32'd1;
  end

`ifdef MTPSA_DROP_FILTER_EN
  // Count packets consumed locally because of the drop bit.
  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn)          drop_cnt <= '0;
    else if (pop & head_drop)  drop_cnt <= drop_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sdnet_to_mtpsa.sv
// Self-checking bench for sdnet_to_mtpsa. It uses a directed vector table, hand-written
// multi-cycle sequences, and a randomised back-pressure run checked against a small model.
module tb_sdnet_to_mtpsa;

  localparam int DW = 256;
  localparam int UW = 304;

  logic          clk = 1'b0;
  logic          resetn;
  logic          tuple_valid;
  logic [127:0]  tuple_data;
  logic [255:0]  digest_data;
  logic [DW-1:0] s_tdata;
  logic [31:0]   s_tkeep;
  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] m_tdata;
  logic [31:0]   m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid, m_tready, m_tlast;
  logic          ovf;
  logic [31:0]   pkt_cnt;
`ifdef MTPSA_DROP_FILTER_EN
  logic [31:0]   drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdnet_to_mtpsa dut (
    .axis_aclk(clk), .axis_resetn(resetn),
    .sdnet_tuple_VALID(tuple_valid), .sdnet_tuple_DATA(tuple_data),
    .sdnet_digest_DATA(digest_data),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .tuple_overflow(ovf), .pkt_cnt(pkt_cnt)
`ifdef MTPSA_DROP_FILTER_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  typedef struct {
    logic tv; logic [47:0] tup; logic [7:0] dg;
    logic sv; logic sl; logic [7:0] dat; logic mr;
    logic e_mv; logic e_sr; logic [47:0] e_tup; logic [7:0] e_dg; logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[13];

  localparam logic [47:0] T1 = 48'hA0B0_1234_5678;
  localparam logic [47:0] T2 = 48'hC0D0_9ABC_DEF0;
  localparam logic [47:0] T3 = 48'h0E00_0F0F_0F0F;

  task automatic chk(input string nm, input logic [UW-1:0] a, input logic [UW-1:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  task automatic settle(); #4; endtask
  task automatic next(); @(posedge clk); #1; endtask

  function automatic logic [UW-1:0] exp_user(input logic [255:0] dg, input logic [47:0] tp);
    return {dg, tp};
  endfunction

  function automatic logic [47:0] qtup(input int k);
    return {8'(8'hA0 + k), 8'h00, 32'h1000_0000 + 32'(k)};
  endfunction

  task automatic push_tuple(input logic [47:0] tp, input logic [255:0] dg);
    tuple_valid = 1'b1;
    tuple_data  = {80'hFFEE_DDCC_BBAA_9988_7766, tp};
    digest_data = dg;
  endtask

  // randomised traffic model storage
  logic [47:0]  rt [100];
  logic [255:0] rdg[100];
  int           nb [100];

  initial begin
    // ---------------- reset state ----------------
    resetn = 1'b0; tuple_valid = 0; tuple_data = '0; digest_data = '0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = 1'b1;
    next(); next();
    settle();
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_sready", s_tready, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    next();
    resetn = 1'b1; s_tvalid = 1'b0;
    next();

    // ---------------- tests 1/2 + back-pressure: vector table ----------------
    //          tv tup dg    sv sl dat mr  e_mv e_sr e_tup e_dg e_cnt
    tbl[0]  = '{1, T1, 8'h11, 0, 0, 0, 1,  0, 0, 0,  0,     0};
    tbl[1]  = '{0, 0,  0,     1, 0, 1, 1,  1, 1, T1, 8'h11, 0};
    tbl[2]  = '{0, 0,  0,     1, 0, 2, 1,  1, 1, T1, 8'h11, 0};
    tbl[3]  = '{0, 0,  0,     1, 1, 3, 1,  1, 1, T1, 8'h11, 0};
    tbl[4]  = '{0, 0,  0,     0, 0, 0, 1,  0, 0, 0,  0,     1};
    tbl[5]  = '{1, T2, 8'h22, 1, 0, 4, 1,  0, 0, 0,  0,     1};
    tbl[6]  = '{0, 0,  0,     1, 0, 4, 1,  1, 1, T2, 8'h22, 1};
    tbl[7]  = '{0, 0,  0,     1, 0, 5, 1,  1, 1, T2, 8'h22, 1};
    tbl[8]  = '{0, 0,  0,     1, 1, 6, 1,  1, 1, T2, 8'h22, 1};
    tbl[9]  = '{1, T3, 8'h33, 0, 0, 0, 1,  0, 0, 0,  0,     2};
    tbl[10] = '{0, 0,  0,     1, 1, 7, 0,  1, 0, T3, 8'h33, 2};
    tbl[11] = '{0, 0,  0,     1, 1, 7, 1,  1, 1, T3, 8'h33, 2};
    tbl[12] = '{0, 0,  0,     1, 0, 8, 1,  0, 0, 0,  0,     3};
    for (int i = 0; i < 13; i++) begin
      tuple_valid = tbl[i].tv;
      tuple_data  = {80'hFFEE_DDCC_BBAA_9988_7766, tbl[i].tup};
      digest_data = {32{tbl[i].dg}};
      s_tvalid = tbl[i].sv; s_tlast = tbl[i].sl; m_tready = tbl[i].mr;
      s_tdata  = {32{tbl[i].dat}}; s_tkeep = {4{tbl[i].dat}};
      settle();
      chk($sformatf("tbl%0d_mvalid", i), m_tvalid, tbl[i].e_mv);
      chk($sformatf("tbl%0d_sready", i), s_tready, tbl[i].e_sr);
      chk($sformatf("tbl%0d_tuser", i), m_tuser,
          (tbl[i].e_mv) ? exp_user({32{tbl[i].e_dg}}, tbl[i].e_tup) : '0);
      chk($sformatf("tbl%0d_pkt_cnt", i), pkt_cnt, tbl[i].e_cnt);
      if (tbl[i].e_mv) begin
        chk($sformatf("tbl%0d_tdata", i), m_tdata, {32{tbl[i].dat}});
        chk($sformatf("tbl%0d_tkeep", i), m_tkeep, {4{tbl[i].dat}});
        chk($sformatf("tbl%0d_tlast", i), m_tlast, tbl[i].sl);
      end
      next();
    end
    s_tvalid = 0; s_tlast = 0; tuple_valid = 0;

    // ---------------- test 3: fill, overflow, push+pop when full ----------------
    for (int k = 1; k <= 4; k++) begin
      push_tuple(qtup(k), {32{8'(k)}});
      next();
    end
    tuple_valid = 0;
    settle();
    chk("t3_ovf_at_full", ovf, 0);
    next();
    push_tuple(qtup(5), {32{8'h05}});
    next();
    tuple_valid = 0;
    settle();
    chk("t3_ovf_set", ovf, 1);
    next();
    // first single-beat packet pops while tuple 6 is pushed into the full FIFO
    s_tvalid = 1; s_tlast = 1; m_tready = 1; s_tdata = {32{8'hE1}};
    push_tuple(qtup(6), {32{8'h06}});
    settle();
    chk("t3_pkt1_sready", s_tready, 1);
    chk("t3_pkt1_tuser", m_tuser, exp_user({32{8'h01}}, qtup(1)));
    next();
    tuple_valid = 0;
    for (int k = 2; k <= 5; k++) begin
      int id;
      id = (k == 5) ? 6 : k;
      settle();
      chk($sformatf("t3_pkt%0d_mvalid", k), m_tvalid, 1);
      chk($sformatf("t3_pkt%0d_tuser", k), m_tuser, exp_user({32{8'(id)}}, qtup(id)));
      next();
    end
    settle();
    chk("t3_empty_mvalid", m_tvalid, 0);
    chk("t3_ovf_sticky", ovf, 1);
    chk("t3_pkt_cnt", pkt_cnt, 8);
    s_tvalid = 0; s_tlast = 0;
    next();

    // ---------------- test 4: randomised back-pressure ----------------
    resetn = 0; next(); resetn = 1; next();
    for (int i = 0; i < 100; i++) begin
      rt[i]  = {$urandom, $urandom} & ~(48'h1 << 32);
      rdg[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      nb[i]  = $urandom_range(1, 24);
    end
    begin
      int  pushed, pkt, beat, cyc;
      bit  sv_keep, hs_s;
      logic [DW-1:0] pat;
      pushed = 0; pkt = 0; beat = 0; cyc = 0; sv_keep = 0;
      while (pkt < 100 && cyc < 20000) begin
        cyc++;
        tuple_valid = 0;
        if (pushed < 100 && (pushed - pkt) < 3 && $urandom_range(0, 1) == 1)
          push_tuple(rt[pushed], rdg[pushed]);
        pat      = {8{16'(pkt), 16'(beat)}};
        s_tvalid = sv_keep | ($urandom_range(0, 3) != 0);
        s_tdata  = pat;
        s_tkeep  = '1;
        s_tlast  = (beat == nb[pkt] - 1);
        m_tready = $urandom_range(0, 1) == 1;
        settle();
        chk("t4_mvalid", m_tvalid, s_tvalid && (pushed > pkt));
        chk("t4_sready", s_tready, m_tready && (pushed > pkt));
        hs_s = s_tvalid & s_tready;
        if (m_tvalid & m_tready) begin
          chk("t4_tuser", m_tuser, exp_user(rdg[pkt], rt[pkt]));
          chk("t4_tdata", m_tdata, pat);
          chk("t4_tlast", m_tlast, beat == nb[pkt] - 1);
        end
        sv_keep = s_tvalid & ~hs_s;
        if (tuple_valid) pushed++;
        if (hs_s) begin
          if (s_tlast) begin pkt++; beat = 0; end
          else beat++;
        end
        next();
      end
      tuple_valid = 0; s_tvalid = 0; s_tlast = 0;
      if (cyc >= 20000) chk("t4_timeout", 1, 0);
      settle();
      chk("t4_pkt_cnt", pkt_cnt, 100);
      chk("t4_ovf", ovf, 0);
      next();
    end

    // ---------------- test 5: reset mid-packet ----------------
    for (int k = 1; k <= 5; k++) begin
      push_tuple(qtup(k), {32{8'(k)}});
      next();
    end
    tuple_valid = 0;
    s_tvalid = 1; s_tlast = 0; m_tready = 1;
    settle();
    chk("t5_pre_ovf", ovf, 1);
    chk("t5_pre_mvalid", m_tvalid, 1);
    next();
    resetn = 0;
    next();
    settle();
    chk("t5_rst_mvalid", m_tvalid, 0);
    chk("t5_rst_sready", s_tready, 0);
    chk("t5_rst_pkt_cnt", pkt_cnt, 0);
    chk("t5_rst_ovf", ovf, 0);
    chk("t5_rst_tuser", m_tuser, 0);
    next();
    resetn = 1;
    next();
    settle();
    chk("t5_fifo_empty", m_tvalid, 0);
    next();
    s_tvalid = 0;

`ifdef MTPSA_DROP_FILTER_EN
    // ---------------- test 6: drop filter ----------------
    begin
      int mbeats;
      mbeats = 0;
      for (int p = 0; p < 3; p++) begin
        push_tuple(qtup(p) | ((p == 1) ? (48'h1 << 32) : 48'h0), {32{8'(p)}});
        next();
      end
      tuple_valid = 0;
      for (int p = 0; p < 3; p++) begin
        for (int b = 0; b < 2; b++) begin
          s_tvalid = 1; s_tlast = (b == 1); m_tready = 1;
          settle();
          chk($sformatf("t6_p%0d_mvalid", p), m_tvalid, p != 1);
          chk($sformatf("t6_p%0d_sready", p), s_tready, 1);
          if (m_tvalid & m_tready) mbeats++;
          next();
        end
      end
      s_tvalid = 0; s_tlast = 0;
      settle();
      chk("t6_drop_cnt", drop_cnt, 1);
      chk("t6_pkt_cnt", pkt_cnt, 2);
      chk("t6_fwd_beats", mbeats, 4);
      next();
    end
`else
    // ---------------- drop bit forwarded unchanged when the filter is absent ----------------
    push_tuple(48'h0001_0000_00AA, {32{8'h5A}});
    next();
    tuple_valid = 0;
    s_tvalid = 1; s_tlast = 1; m_tready = 1;
    settle();
    chk("nodrop_mvalid", m_tvalid, 1);
    chk("nodrop_tuser", m_tuser, exp_user({32{8'h5A}}, 48'h0001_0000_00AA));
    next();
    s_tvalid = 0; s_tlast = 0;
    settle();
    chk("nodrop_pkt_cnt", pkt_cnt, 1);
    next();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
